// File: rtl/mc_control_fsm_if.sv
// Control/datapath bundle for the multicycle ARM-subset controller.
// master = controller side, slave = datapath side.
interface mc_control_fsm_if;
  logic [31:0] instr;
  logic [3:0]  alu_flags;
  logic        mem_ready;
  logic        pc_write;
  logic        ir_write;
  logic        mem_write;
  logic        reg_write;
  logic        adr_src;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  result_src;
  logic [1:0]  alu_control;
  logic [1:0]  imm_src;
  logic [1:0]  reg_src;
  logic        bus_err;
  logic [3:0]  state_o;

  modport master (
    input  instr,
    input  alu_flags,
    input  mem_ready,
    output pc_write,
    output ir_write,
    output mem_write,
    output reg_write,
    output adr_src,
    output alu_src_a,
    output alu_src_b,
    output result_src,
    output alu_control,
    output imm_src,
    output reg_src,
    output bus_err,
    output state_o
  );

  modport slave (
    output instr,
    output alu_flags,
    output mem_ready,
    input  pc_write,
    input  ir_write,
    input  mem_write,
    input  reg_write,
    input  adr_src,
    input  alu_src_a,
    input  alu_src_b,
    input  result_src,
    input  alu_control,
    input  imm_src,
    input  reg_src,
    input  bus_err,
    input  state_o
  );
endinterface

// File: rtl/mc_control_fsm.sv
// Multicycle control FSM: fetch/decode/exec/mem/wb sequencing,
// NZCV flag register, condition check and memory-wait watchdog.
module mc_control_fsm #(
  parameter int TO_W    = 4,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  mc_control_fsm_if.master  bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [3:0]      r_flags;
  logic [TO_W-1:0] r_to;

  logic [1:0] w_op;
  logic       w_imm;
  logic [3:0] w_cmd;
  logic       w_s;
  logic [3:0] w_rd;
  logic [3:0] w_cond;
  logic       w_unused;

  assign w_op   = bus.instr[27:26];
  assign w_imm  = bus.instr[25];
  assign w_cmd  = bus.instr[24:21];
  assign w_s    = bus.instr[20];
  assign w_rd   = bus.instr[15:12];
  assign w_cond = bus.instr[31:28];
  assign w_unused = ^{bus.instr[19:16],
                      bus.instr[11:0]};

  logic [1:0] w_alu_dp;
  logic       w_cmd_ok;
  logic       w_is_cmp;
  logic       w_is_log;

  always_comb begin
    w_alu_dp = 2'b00;
    w_cmd_ok = 1'b1;
    w_is_cmp = 1'b0;
    w_is_log = 1'b0;
    unique case (w_cmd)
      4'b0100: w_alu_dp = 2'b00;
      4'b0010: w_alu_dp = 2'b01;
      4'b1010: begin
        w_alu_dp = 2'b01;
        w_is_cmp = 1'b1;
      end
      4'b0000: begin
        w_alu_dp = 2'b10;
        w_is_log = 1'b1;
      end
      4'b1100: begin
        w_alu_dp = 2'b11;
        w_is_log = 1'b1;
      end
      default: w_cmd_ok = 1'b0;
    endcase
  end

  logic w_n, w_z, w_c, w_v;
  logic w_cond_ex;

  assign {w_n, w_z, w_c, w_v} = r_flags;

  always_comb begin
    w_cond_ex = 1'b0;
    unique case (w_cond)
      4'b0000: w_cond_ex = w_z;
      4'b0001: w_cond_ex = ~w_z;
      4'b0010: w_cond_ex = w_c;
      4'b0011: w_cond_ex = ~w_c;
      4'b0100: w_cond_ex = w_n;
      4'b0101: w_cond_ex = ~w_n;
      4'b0110: w_cond_ex = w_v;
      4'b0111: w_cond_ex = ~w_v;
      4'b1000: w_cond_ex = w_c & ~w_z;
      4'b1001: w_cond_ex = ~w_c | w_z;
      4'b1010: w_cond_ex = (w_n == w_v);
      4'b1011: w_cond_ex = (w_n != w_v);
      4'b1100: w_cond_ex = ~w_z & (w_n == w_v);
      4'b1101: w_cond_ex = w_z | (w_n != w_v);
      4'b1110: w_cond_ex = 1'b1;
      default: w_cond_ex = 1'b0;
    endcase
  end

  logic w_wait;
  logic w_to_hit;

  assign w_wait = (r_state == S_FETCH) |
                  (r_state == S_MEMRD) |
                  (r_state == S_MEMWR);
  assign w_to_hit = w_wait & ~bus.mem_ready &
                    (r_to == TO_W'(TIMEOUT));

  logic       w_pc_write;
  logic       w_ir_write;
  logic       w_mem_write;
  logic       w_reg_write;
  logic       w_bus_err;
  logic       w_adr_src;
  logic       w_src_a;
  logic [1:0] w_src_b;
  logic [1:0] w_res;
  logic [1:0] w_alu;
  logic [1:0] w_imm_src;
  logic [1:0] w_reg_src;

  always_comb begin
    w_next      = r_state;
    w_pc_write  = 1'b0;
    w_ir_write  = 1'b0;
    w_mem_write = 1'b0;
    w_reg_write = 1'b0;
    w_bus_err   = 1'b0;
    w_adr_src   = 1'b0;
    w_src_a     = 1'b0;
    w_src_b     = 2'b00;
    w_res       = 2'b00;
    w_alu       = 2'b00;
    w_imm_src   = 2'b00;
    w_reg_src   = 2'b00;
    unique case (r_state)
      S_FETCH: begin
        w_src_a    = 1'b1;
        w_src_b    = 2'b10;
        w_res      = 2'b10;
        w_pc_write = bus.mem_ready;
        w_ir_write = bus.mem_ready;
        if (bus.mem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        w_src_a   = 1'b1;
        w_src_b   = 2'b10;
        w_res     = 2'b10;
        w_reg_src = {(w_op == 2'b01) & ~w_s,
                     (w_op == 2'b10)};
        unique case (1'b1)
          (w_op == 2'b01): w_imm_src = 2'b01;
          (w_op == 2'b10): w_imm_src = 2'b10;
          default:         w_imm_src = 2'b00;
        endcase
        if (!w_cond_ex) begin
          w_next = S_FETCH;
        end else begin
          unique case (w_op)
            2'b00:   w_next = w_imm ? S_EXECI
                                    : S_EXECR;
            2'b01:   w_next = S_MEMADR;
            2'b10:   w_next = S_BRANCH;
            default: w_next = S_FETCH;
          endcase
        end
      end
      S_MEMADR: begin
        w_src_b   = 2'b01;
        w_imm_src = 2'b01;
        w_next    = w_s ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        w_adr_src = 1'b1;
        if (bus.mem_ready) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        w_res       = 2'b01;
        w_reg_write = 1'b1;
        w_next      = S_FETCH;
      end
      S_MEMWR: begin
        w_adr_src   = 1'b1;
        w_mem_write = 1'b1;
        if (bus.mem_ready) w_next = S_FETCH;
      end
      S_EXECR: begin
        w_alu  = w_alu_dp;
        w_next = S_ALUWB;
      end
      S_EXECI: begin
        w_src_b = 2'b01;
        w_alu   = w_alu_dp;
        w_next  = S_ALUWB;
      end
      S_ALUWB: begin
        w_alu       = w_alu_dp;
        w_reg_write = w_cmd_ok & ~w_is_cmp;
        w_pc_write  = (w_rd == 4'hf) & ~w_is_cmp;
        w_next      = S_FETCH;
      end
      S_BRANCH: begin
        w_src_b    = 2'b01;
        w_imm_src  = 2'b10;
        w_res      = 2'b10;
        w_pc_write = 1'b1;
        w_next     = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
    // a late mem_ready never reaches here: w_to_hit needs ready low
    if (w_to_hit) begin
      w_bus_err = 1'b1;
      w_next    = S_FETCH;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_to <= '0;
    end else if (!w_wait || bus.mem_ready ||
                 w_to_hit) begin
      r_to <= '0;
    end else begin
      r_to <= r_to + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_flags <= 4'b0000;
    end else if (((r_state == S_EXECR) ||
                  (r_state == S_EXECI)) && w_s) begin
      if (w_is_log) begin
        r_flags[3:2] <= bus.alu_flags[3:2];
      end else begin
        r_flags <= bus.alu_flags;
      end
    end
  end

  assign bus.pc_write    = w_pc_write  & reset_n;
  assign bus.ir_write    = w_ir_write  & reset_n;
  assign bus.mem_write   = w_mem_write & reset_n;
  assign bus.reg_write   = w_reg_write & reset_n;
  assign bus.bus_err     = w_bus_err   & reset_n;
  assign bus.adr_src     = w_adr_src;
  assign bus.alu_src_a   = w_src_a;
  assign bus.alu_src_b   = w_src_b;
  assign bus.result_src  = w_res;
  assign bus.alu_control = w_alu;
  assign bus.imm_src     = w_imm_src;
  assign bus.reg_src     = w_reg_src;
  assign bus.state_o     = r_state;

endmodule
